// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: word/select widths, writeback source and load type encodings.
package cpu_types_pkg;
    localparam int WORD_W = 32;
    localparam int RSEL_W = 5;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_NPC = 2'd2,
        WB_LUI = 2'd3
    } wbsrc_t;

    typedef enum logic [2:0] {
        LD_W  = 3'd0,
        LD_B  = 3'd1,
        LD_BU = 3'd2,
        LD_H  = 3'd3,
        LD_HU = 3'd4
    } ldtype_t;
endpackage

// File: rtl/writeback_stage_if.sv
// MEM -> WB result bundle; the memory stage drives it (master), the WB latch samples it (slave).
interface writeback_stage_if
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W,
    parameter int RSEL_W = cpu_types_pkg::RSEL_W
) ();
    logic              mem_valid;
    logic              mem_stall;
    logic              mem_flush;
    logic              mem_regwen;
    logic [RSEL_W-1:0] mem_wsel;
    wbsrc_t            mem_wbsrc;
    logic [WORD_W-1:0] mem_aluout;
    logic [WORD_W-1:0] mem_dload;
    logic [WORD_W-1:0] mem_npc;
    logic [15:0]       mem_imm16;
    ldtype_t           mem_ldtype;
    logic              mem_halt;

    modport master (
        output mem_valid, mem_stall, mem_flush, mem_regwen, mem_wsel, mem_wbsrc,
               mem_aluout, mem_dload, mem_npc, mem_imm16, mem_ldtype, mem_halt
    );

    modport slave (
        input  mem_valid, mem_stall, mem_flush, mem_regwen, mem_wsel, mem_wbsrc,
               mem_aluout, mem_dload, mem_npc, mem_imm16, mem_ldtype, mem_halt
    );
endinterface

// File: rtl/writeback_stage_load_align.sv
// Big-endian subword load alignment: byte 0 is [31:24]; halves are picked by offset bit 1.
module load_align
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W
) (
    input  logic [WORD_W-1:0] word_i,
    input  logic [1:0]        off_i,
    input  ldtype_t           ldtype_i,
    output logic [WORD_W-1:0] word_o
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = word_i[31:24];
        case (off_i)
            2'd0:    byte_sel = word_i[31:24];
            2'd1:    byte_sel = word_i[23:16];
            2'd2:    byte_sel = word_i[15:8];
            default: byte_sel = word_i[7:0];
        endcase
        // A misaligned half ignores offset bit 0 rather than trapping.
        half_sel = off_i[1] ? word_i[15:0] : word_i[31:16];
    end

    always_comb begin
        word_o = word_i;
        case (ldtype_i)
            LD_B:    word_o = {{(WORD_W-8){byte_sel[7]}}, byte_sel};
            LD_BU:   word_o = {{(WORD_W-8){1'b0}}, byte_sel};
            LD_H:    word_o = {{(WORD_W-16){half_sel[15]}}, half_sel};
            LD_HU:   word_o = {{(WORD_W-16){1'b0}}, half_sel};
            default: word_o = word_i;
        endcase
    end
endmodule

// File: rtl/writeback_stage.sv
// MEM/WB latch, writeback select, sticky halt and retired counter.
// Subword load alignment is built only when WB_SUBWORD_LOAD_EN is defined.
module writeback_stage
    import cpu_types_pkg::*;
#(
    parameter int WORD_W = cpu_types_pkg::WORD_W,
    parameter int RSEL_W = cpu_types_pkg::RSEL_W
) (
    input  logic                CLK,
    input  logic                RST,
    writeback_stage_if.slave    m,
    output logic                rf_wen,
    output logic [RSEL_W-1:0]   rf_wsel,
    output logic [WORD_W-1:0]   rf_wdat,
    output logic                halt,
    output logic [31:0]         retired
);
    typedef struct packed {
        logic              valid;
        logic              regwen;
        logic [RSEL_W-1:0] wsel;
        wbsrc_t            wbsrc;
        logic [WORD_W-1:0] aluout;
        logic [WORD_W-1:0] dload;
        logic [WORD_W-1:0] npc;
        logic [15:0]       imm16;
        logic              halt;
`ifdef WB_SUBWORD_LOAD_EN
        ldtype_t           ldtype;
`endif
    } wb_t;

    wb_t         wb_d, wb_q;
    logic        halted_d, halted_q;
    logic [31:0] retired_d, retired_q;
    logic [WORD_W-1:0] load_word;

    always_comb begin
        wb_d      = wb_q;
        halted_d  = halted_q | (wb_q.valid & wb_q.halt);
        // A stalled instruction retires only on the edge where it leaves WB.
        retired_d = retired_q + 32'(wb_q.valid & ~m.mem_stall & ~halted_q);
        if (halted_q) begin
            wb_d.valid = 1'b0;
        end else if (m.mem_flush) begin
            wb_d.valid = 1'b0;
        end else if (!m.mem_stall) begin
            wb_d.valid  = m.mem_valid;
            wb_d.regwen = m.mem_regwen;
            wb_d.wsel   = m.mem_wsel;
            wb_d.wbsrc  = m.mem_wbsrc;
            wb_d.aluout = m.mem_aluout;
            wb_d.dload  = m.mem_dload;
            wb_d.npc    = m.mem_npc;
            wb_d.imm16  = m.mem_imm16;
            wb_d.halt   = m.mem_halt;
`ifdef WB_SUBWORD_LOAD_EN
            wb_d.ldtype = m.mem_ldtype;
`endif
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wb_q      <= '0;
            halted_q  <= 1'b0;
            retired_q <= '0;
        end else begin
            wb_q      <= wb_d;
            halted_q  <= halted_d;
            retired_q <= retired_d;
        end
    end

`ifdef WB_SUBWORD_LOAD_EN
    load_align #(.WORD_W(WORD_W)) u_load_align (
        .word_i   (wb_q.dload),
        .off_i    (wb_q.aluout[1:0]),
        .ldtype_i (wb_q.ldtype),
        .word_o   (load_word)
    );
`else
    logic unused_ldtype;
    assign unused_ldtype = ^m.mem_ldtype;
    assign load_word     = wb_q.dload;
`endif

    always_comb begin
        rf_wdat = wb_q.aluout;
        case (wb_q.wbsrc)
            WB_ALU:  rf_wdat = wb_q.aluout;
            WB_MEM:  rf_wdat = load_word;
            WB_NPC:  rf_wdat = wb_q.npc;
            WB_LUI:  rf_wdat = {wb_q.imm16, {(WORD_W-16){1'b0}}};
            default: rf_wdat = wb_q.aluout;
        endcase
    end

    // $0 is hardwired, and a HALT never writes even if it carries regwen.
    assign rf_wen  = wb_q.valid & wb_q.regwen & (wb_q.wsel != '0) & ~wb_q.halt & ~halted_q;
    assign rf_wsel = wb_q.wsel;
    assign halt    = halted_q;
    assign retired = retired_q;
endmodule

// File: tb/tb_writeback_stage.sv
// Directed bench for writeback_stage: vector table for select paths, hand sequences for stall/flush/halt/reset.
module tb_writeback_stage;
    import cpu_types_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        rf_wen;
    logic [4:0]  rf_wsel;
    logic [31:0] rf_wdat;
    logic        halt;
    logic [31:0] retired;

    int checks = 0;
    int errors = 0;

    writeback_stage_if #(.WORD_W(32), .RSEL_W(5)) wbif ();

    writeback_stage #(.WORD_W(32), .RSEL_W(5)) dut (
        .CLK     (CLK),
        .RST     (RST),
        .m       (wbif.slave),
        .rf_wen  (rf_wen),
        .rf_wsel (rf_wsel),
        .rf_wdat (rf_wdat),
        .halt    (halt),
        .retired (retired)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        string       name;
        logic        regwen;
        logic [4:0]  wsel;
        wbsrc_t      src;
        logic [31:0] alu;
        logic [31:0] dload;
        logic [31:0] npc;
        logic [15:0] imm;
        ldtype_t     ld;
        logic        exp_wen;
        logic [31:0] exp_wdat;
    } vec_t;

    vec_t tbl[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle();
        wbif.mem_valid  = 1'b0;
        wbif.mem_stall  = 1'b0;
        wbif.mem_flush  = 1'b0;
        wbif.mem_regwen = 1'b0;
        wbif.mem_wsel   = '0;
        wbif.mem_wbsrc  = WB_ALU;
        wbif.mem_aluout = '0;
        wbif.mem_dload  = '0;
        wbif.mem_npc    = '0;
        wbif.mem_imm16  = '0;
        wbif.mem_ldtype = LD_W;
        wbif.mem_halt   = 1'b0;
    endtask

    task automatic write_alu(input logic [4:0] wsel, input logic [31:0] val);
        idle();
        wbif.mem_valid  = 1'b1;
        wbif.mem_regwen = 1'b1;
        wbif.mem_wsel   = wsel;
        wbif.mem_aluout = val;
    endtask

    task automatic apply(input vec_t v);
        idle();
        wbif.mem_valid  = 1'b1;
        wbif.mem_regwen = v.regwen;
        wbif.mem_wsel   = v.wsel;
        wbif.mem_wbsrc  = v.src;
        wbif.mem_aluout = v.alu;
        wbif.mem_dload  = v.dload;
        wbif.mem_npc    = v.npc;
        wbif.mem_imm16  = v.imm;
        wbif.mem_ldtype = v.ld;
    endtask

    task automatic cyc();
        @(posedge CLK);
        @(negedge CLK);
    endtask

    initial begin
        logic [31:0] exp_ret;
        logic [31:0] sw_b0, sw_bu0, sw_h2, sw_hu0, sw_b3, sw_b1, sw_bu1, sw_h1;
`ifdef WB_SUBWORD_LOAD_EN
        sw_b0 = 32'hFFFFFF80; sw_bu0 = 32'h00000080; sw_h2 = 32'h00007F01; sw_hu0 = 32'h000080FF;
        sw_b3 = 32'h00000001; sw_b1  = 32'hFFFFFFFF; sw_bu1 = 32'h000000FF; sw_h1 = 32'hFFFF80FF;
`else
        sw_b0 = 32'h80FF7F01; sw_bu0 = 32'h80FF7F01; sw_h2 = 32'h80FF7F01; sw_hu0 = 32'h80FF7F01;
        sw_b3 = 32'h80FF7F01; sw_b1  = 32'h80FF7F01; sw_bu1 = 32'h80FF7F01; sw_h1 = 32'h80FF7F01;
`endif
        tbl[0]  = '{"alu",     1'b1, 5'd5,  WB_ALU, 32'hDEADBEEF, 32'h0,        32'h0,  16'h0,    LD_W,  1'b1, 32'hDEADBEEF};
        tbl[1]  = '{"wsel0",   1'b1, 5'd0,  WB_ALU, 32'h12345678, 32'h0,        32'h0,  16'h0,    LD_W,  1'b0, 32'h12345678};
        tbl[2]  = '{"lui",     1'b1, 5'd9,  WB_LUI, 32'h0,        32'h0,        32'h0,  16'h1234, LD_W,  1'b1, 32'h12340000};
        tbl[3]  = '{"npc",     1'b1, 5'd31, WB_NPC, 32'h0,        32'h0,        32'h44, 16'h0,    LD_W,  1'b1, 32'h00000044};
        tbl[4]  = '{"noregwen",1'b0, 5'd4,  WB_ALU, 32'hAAAA5555, 32'h0,        32'h0,  16'h0,    LD_W,  1'b0, 32'hAAAA5555};
        tbl[5]  = '{"ld_b0",   1'b1, 5'd1,  WB_MEM, 32'h00000100, 32'h80FF7F01, 32'h0,  16'h0,    LD_B,  1'b1, sw_b0};
        tbl[6]  = '{"ld_bu0",  1'b1, 5'd2,  WB_MEM, 32'h00000200, 32'h80FF7F01, 32'h0,  16'h0,    LD_BU, 1'b1, sw_bu0};
        tbl[7]  = '{"ld_h2",   1'b1, 5'd3,  WB_MEM, 32'h00000102, 32'h80FF7F01, 32'h0,  16'h0,    LD_H,  1'b1, sw_h2};
        tbl[8]  = '{"ld_hu0",  1'b1, 5'd4,  WB_MEM, 32'h00000000, 32'h80FF7F01, 32'h0,  16'h0,    LD_HU, 1'b1, sw_hu0};
        tbl[9]  = '{"ld_b3",   1'b1, 5'd5,  WB_MEM, 32'h00000003, 32'h80FF7F01, 32'h0,  16'h0,    LD_B,  1'b1, sw_b3};
        tbl[10] = '{"ld_b1",   1'b1, 5'd6,  WB_MEM, 32'h00000001, 32'h80FF7F01, 32'h0,  16'h0,    LD_B,  1'b1, sw_b1};
        tbl[11] = '{"ld_bu1",  1'b1, 5'd7,  WB_MEM, 32'h00000001, 32'h80FF7F01, 32'h0,  16'h0,    LD_BU, 1'b1, sw_bu1};
        tbl[12] = '{"ld_h1",   1'b1, 5'd8,  WB_MEM, 32'h00000001, 32'h80FF7F01, 32'h0,  16'h0,    LD_H,  1'b1, sw_h1};

        idle();
        #12;
        check("rst_wen",     32'(rf_wen),  32'd0);
        check("rst_wdat",    rf_wdat,      32'd0);
        check("rst_halt",    32'(halt),    32'd0);
        check("rst_retired", retired,      32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // basic write and its retirement one edge later
        apply(tbl[0]);
        cyc();
        check("basic_wen",  32'(rf_wen),  32'd1);
        check("basic_wsel", 32'(rf_wsel), 32'd5);
        check("basic_wdat", rf_wdat,      32'hDEADBEEF);
        check("basic_ret0", retired,      32'd0);
        idle();
        cyc();
        check("basic_ret1", retired,      32'd1);
        check("bubble_wen", 32'(rf_wen),  32'd0);
        exp_ret = 32'd1;

        for (int i = 0; i < 13; i++) begin
            apply(tbl[i]);
            cyc();
            check({tbl[i].name, "_wen"},  32'(rf_wen),  32'(tbl[i].exp_wen));
            check({tbl[i].name, "_wsel"}, 32'(rf_wsel), 32'(tbl[i].wsel));
            check({tbl[i].name, "_wdat"}, rf_wdat,      tbl[i].exp_wdat);
        end
        idle();
        cyc();
        exp_ret = exp_ret + 32'd13;
        check("table_retired", retired, exp_ret);

        // stall holds A for three cycles, counts it once on release
        write_alu(5'd7, 32'h11111111);
        cyc();
        check("stallA_wen", 32'(rf_wen), 32'd1);
        write_alu(5'd8, 32'h22222222);
        wbif.mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("stall_wen",  32'(rf_wen),  32'd1);
            check("stall_wsel", 32'(rf_wsel), 32'd7);
            check("stall_wdat", rf_wdat,      32'h11111111);
            check("stall_ret",  retired,      exp_ret);
        end
        idle();
        cyc();
        exp_ret = exp_ret + 32'd1;
        check("release_ret", retired,     exp_ret);
        check("release_wen", 32'(rf_wen), 32'd0);

        // flush wins over stall
        write_alu(5'd10, 32'h33333333);
        cyc();
        check("flushB_wen", 32'(rf_wen), 32'd1);
        write_alu(5'd11, 32'h44444444);
        wbif.mem_stall = 1'b1;
        wbif.mem_flush = 1'b1;
        cyc();
        check("flush_wen", 32'(rf_wen), 32'd0);
        check("flush_ret", retired,     exp_ret);
        idle();
        cyc();

        // HALT: no write itself, counted, then everything freezes
        write_alu(5'd3, 32'h00000099);
        wbif.mem_halt = 1'b1;
        cyc();
        check("halt_inwb_wen",  32'(rf_wen), 32'd0);
        check("halt_inwb_halt", 32'(halt),   32'd0);
        write_alu(5'd12, 32'h00005555);
        cyc();
        exp_ret = exp_ret + 32'd1;
        check("halt_set",     32'(halt),   32'd1);
        check("halt_wen",     32'(rf_wen), 32'd0);
        check("halt_retired", retired,     exp_ret);
        for (int i = 0; i < 2; i++) begin
            write_alu(5'd13 + 5'(i), 32'h0000AAAA);
            cyc();
            check("halted_wen",  32'(rf_wen), 32'd0);
            check("halted_ret",  retired,     exp_ret);
            check("halted_halt", 32'(halt),   32'd1);
        end

        RST = 1'b1;
        #1;
        check("halt_clr", 32'(halt), 32'd0);
        idle();
        @(negedge CLK);
        RST = 1'b0;

        // asynchronous reset mid-cycle with a live write in the latch
        write_alu(5'd6, 32'hCAFEF00D);
        cyc();
        check("pre_rst_wen", 32'(rf_wen), 32'd1);
        @(posedge CLK);
        #2;
        check("pre_rst_ret", retired, 32'd1);
        RST = 1'b1;
        #1;
        check("midrst_wen",  32'(rf_wen),  32'd0);
        check("midrst_wdat", rf_wdat,      32'd0);
        check("midrst_halt", 32'(halt),    32'd0);
        check("midrst_ret",  retired,      32'd0);
        cyc();
        check("rsthold_wen", 32'(rf_wen),  32'd0);
        check("rsthold_ret", retired,      32'd0);
        RST = 1'b0;
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
